// File: rtl/truncador_sat_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : truncador_sat_pipe_pkg
//  Brief    : Shared fixed-point defaults and helpers for the requantiser.
//  Revision : 1.0 - initial release
// ============================================================================
package truncador_sat_pipe_pkg;

    // Default fixed-point geometry of the filter datapath and DAC code
    localparam int c_N_DEF        = 16;
    localparam int c_F_DEF        = 10;
    localparam int c_OUT_W_DEF    = 8;
    localparam int c_CHANNELS_DEF = 2;
    localparam int c_CNT_W_DEF    = 16;

    // Number of LSBs discarded when moving from F fractional bits to an
    // OUT_W-bit code spanning [-1,1)
    function automatic int shift_amt(input int f, input int out_w);
        return f - (out_w - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/truncador_sat_pipe_trunc_lane.sv
`default_nettype none
// ============================================================================
//  Module   : trunc_lane
//  Brief    : One lane of the second stage: arithmetic shift of the rounded
//             sum, clamp to the OUT_W-bit range, optional offset-binary MSB.
//  Revision : 1.0 - initial release
// ============================================================================
module trunc_lane
    import truncador_sat_pipe_pkg::*;
#(
    parameter int N     = c_N_DEF,
    parameter int F     = c_F_DEF,
    parameter int OUT_W = c_OUT_W_DEF
) (
    input  logic [N:0]       i_t,
    input  logic             i_offset,
    output logic [OUT_W-1:0] o_code,
    output logic             o_sat_hi,
    output logic             o_sat_lo
);

    localparam int                c_S        = shift_amt(F, OUT_W);
    localparam logic signed [N:0] c_MAX      = (N+1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [N:0] c_MIN      = (N+1)'(-(2 ** (OUT_W - 1)));
    localparam logic [OUT_W-1:0]  c_CODE_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]  c_CODE_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic signed [N:0] w_r;
    logic [OUT_W-1:0]  w_code;

    // Floor division by 2^S; the rounding bias was already added upstream
    assign w_r = $signed(i_t) >>> c_S;

    // Clamp first, then apply the output format so flags refer to the value
    always_comb begin
        w_code   = w_r[OUT_W-1:0];
        o_sat_hi = 1'b0;
        o_sat_lo = 1'b0;
        if (w_r > c_MAX) begin
            w_code   = c_CODE_MAX;
            o_sat_hi = 1'b1;
        end else if (w_r < c_MIN) begin
            w_code   = c_CODE_MIN;
            o_sat_lo = 1'b1;
        end
        o_code = i_offset ? (w_code ^ c_CODE_MIN) : w_code;
    end

endmodule
`default_nettype wire

// File: rtl/truncador_sat_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : truncador_sat_pipe
//  Brief    : Multi-channel two-stage requantiser from signed fixed-point
//             samples to DAC codes, elastic valid/ready on both sides, with
//             per-lane saturation flags and a saturating event counter.
//  Revision : 1.0 - initial release
// ============================================================================
module truncador_sat_pipe
    import truncador_sat_pipe_pkg::*;
#(
    parameter int N        = c_N_DEF,
    parameter int F        = c_F_DEF,
    parameter int OUT_W    = c_OUT_W_DEF,
    parameter int CHANNELS = c_CHANNELS_DEF,
    parameter int CNT_W    = c_CNT_W_DEF
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*N-1:0]     in_data,
    input  logic                      mode_round,
    input  logic                      mode_offset,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*OUT_W-1:0] out_data,
    output logic [CHANNELS-1:0]       out_sat_hi,
    output logic [CHANNELS-1:0]       out_sat_lo,
    input  logic                      clr_count,
    output logic [CNT_W-1:0]          sat_count
);

    localparam int         c_S    = shift_amt(F, OUT_W);
    // Half an output LSB, expressed in input LSBs; zero when nothing is dropped
    localparam logic [N:0] c_BIAS = (c_S > 0) ? ((N+1)'(1) << ((c_S > 0) ? (c_S - 1) : 0)) : '0;

    logic                      w_adv1;
    logic                      w_adv2;
    logic                      w_xfer;
    logic                      w_any;
    logic [N:0]                w_s1_sum [CHANNELS];
    logic [CHANNELS*OUT_W-1:0] w_code;
    logic [CHANNELS-1:0]       w_hi;
    logic [CHANNELS-1:0]       w_lo;

    logic                      r_s1_valid;
    logic [N:0]                r_s1_t [CHANNELS];
    logic                      r_s1_offset;
    logic                      r_s2_valid;
    logic [CHANNELS*OUT_W-1:0] r_out_data;
    logic [CHANNELS-1:0]       r_sat_hi;
    logic [CHANNELS-1:0]       r_sat_lo;
    logic [CNT_W-1:0]          r_count;

    // A stage may load when it is empty or the stage after it is moving
    assign w_adv2   = ~r_s2_valid | out_ready;
    assign w_adv1   = ~r_s1_valid | w_adv2;
    assign in_ready = w_adv1 & ~RST;
    assign w_xfer   = r_s2_valid & out_ready;
    assign w_any    = |(r_sat_hi | r_sat_lo);

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
            // One extra bit of headroom so adding the bias can never wrap
            assign w_s1_sum[k] = {in_data[k*N+N-1], in_data[k*N +: N]}
                               + (mode_round ? c_BIAS : '0);

            trunc_lane #(
                .N     (N),
                .F     (F),
                .OUT_W (OUT_W)
            ) u_lane (
                .i_t      (r_s1_t[k]),
                .i_offset (r_s1_offset),
                .o_code   (w_code[k*OUT_W +: OUT_W]),
                .o_sat_hi (w_hi[k]),
                .o_sat_lo (w_lo[k])
            );
        end
    endgenerate

    // Stage 1: capture the widened, optionally biased sums with the beat's format
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1_valid <= 1'b0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_t      <= w_s1_sum;
                r_s1_offset <= mode_offset;
            end
        end
    end

    // Stage 2: register clamped codes and flags; held while downstream stalls
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s2_valid <= 1'b0;
            r_out_data <= '0;
            r_sat_hi   <= '0;
            r_sat_lo   <= '0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_code;
                r_sat_hi   <= w_hi;
                r_sat_lo   <= w_lo;
            end
        end
    end

    // Count flagged output transfers; clear takes priority, no wrap at all-ones
    always_ff @(posedge CLK) begin
        if (RST || clr_count) begin
            r_count <= '0;
        end else if (w_xfer && w_any && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_data   = r_out_data;
    assign out_sat_hi = r_sat_hi;
    assign out_sat_lo = r_sat_lo;
    assign sat_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_truncador_sat_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_truncador_sat_pipe
//  Brief    : Scoreboard bench for truncador_sat_pipe (N=16, F=10, OUT_W=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_truncador_sat_pipe;

    localparam int N     = 16;
    localparam int F     = 10;
    localparam int OUT_W = 8;
    localparam int CH    = 2;
    localparam int CNT_W = 16;
    localparam int SH    = F - (OUT_W - 1);
    localparam int CMAX  = (2 ** (OUT_W - 1)) - 1;
    localparam int CMIN  = -(2 ** (OUT_W - 1));

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CH*N-1:0]   in_data = '0;
    logic              mode_round = 1'b0;
    logic              mode_offset = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [CH*OUT_W-1:0] out_data;
    logic [CH-1:0]     out_sat_hi;
    logic [CH-1:0]     out_sat_lo;
    logic              clr_count = 1'b0;
    logic [CNT_W-1:0]  sat_count;

    logic              small_valid = 1'b0;
    logic              small_in_ready;
    logic              small_out_valid;
    logic [CH*OUT_W-1:0] small_out_data;
    logic [CH-1:0]     small_hi;
    logic [CH-1:0]     small_lo;
    logic [2:0]        small_count;

    typedef struct {
        logic [CH*OUT_W-1:0] data;
        logic [CH-1:0]       hi;
        logic [CH-1:0]       lo;
        int                  acc;
        bit                  lat;
    } exp_t;

    exp_t sb[$];
    int   total   = 0;
    int   bad     = 0;
    int   cyc     = 0;
    int   cnt_m   = 0;
    int   bp_mode = 0;   // 0: out_ready=1, 1: random, 2: driven by the test

    truncador_sat_pipe #(
        .N(N), .F(F), .OUT_W(OUT_W), .CHANNELS(CH), .CNT_W(CNT_W)
    ) u_dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mode_round(mode_round), .mode_offset(mode_offset),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat_hi(out_sat_hi), .out_sat_lo(out_sat_lo),
        .clr_count(clr_count), .sat_count(sat_count)
    );

    // Narrow counter instance used only to reach the counter ceiling quickly
    truncador_sat_pipe #(
        .N(N), .F(F), .OUT_W(OUT_W), .CHANNELS(CH), .CNT_W(3)
    ) u_small (
        .CLK(CLK), .RST(RST),
        .in_valid(small_valid), .in_ready(small_in_ready), .in_data(in_data),
        .mode_round(mode_round), .mode_offset(mode_offset),
        .out_valid(small_out_valid), .out_ready(1'b1), .out_data(small_out_data),
        .out_sat_hi(small_hi), .out_sat_lo(small_lo),
        .clr_count(1'b0), .sat_count(small_count)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Reference: value = x / 2^F; code = floor(value * 2^(OUT_W-1) [+ 0.5]), clamped
    function automatic void model_lane(input logic [N-1:0] x, input bit rnd, input bit off,
                                       output logic [OUT_W-1:0] code, output bit hi, output bit lo);
        int v, r, div;
        div = 2 ** SH;
        v   = int'($signed(x));
        if (rnd && SH > 0) v = v + div / 2;
        if (v >= 0) r = v / div;
        else        r = -((-v + div - 1) / div);
        hi = (r > CMAX);
        lo = (r < CMIN);
        if (hi) r = CMAX;
        if (lo) r = CMIN;
        code = OUT_W'(r);
        if (off) code = code ^ {1'b1, {(OUT_W-1){1'b0}}};
    endfunction

    function automatic logic [N-1:0] rand_x();
        int sel, v;
        sel = $urandom_range(0, 2);
        case (sel)
            0:       v = int'($urandom_range(0, 65535));
            1:       v = int'($urandom_range(0, 2560)) - 1280;
            default: v = (int'($urandom_range(0, 16)) + 1016) * (($urandom_range(0, 1) == 1) ? 1 : -1);
        endcase
        return N'(v);
    endfunction

    // Input side: every accepted beat pushes its expected response
    always @(negedge CLK) begin : p_in_mon
        exp_t e;
        logic [OUT_W-1:0] c;
        bit h, l;
        if (!RST && in_valid && in_ready) begin
            for (int k = 0; k < CH; k++) begin
                model_lane(in_data[k*N +: N], mode_round, mode_offset, c, h, l);
                e.data[k*OUT_W +: OUT_W] = c;
                e.hi[k] = h;
                e.lo[k] = l;
            end
            e.acc = cyc;
            e.lat = (bp_mode == 0);
            sb.push_back(e);
        end
    end

    // Output side: pop and compare on each transfer; track the expected counter
    always @(negedge CLK) begin : p_out_mon
        exp_t e;
        if (RST) begin
            cnt_m = 0;
        end else begin
            total++;
            if (sat_count !== CNT_W'(cnt_m)) begin
                bad++;
                $display("FAIL sat_count got=%0d want=%0d (cycle %0d)", sat_count, cnt_m, cyc);
            end
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL out_beat unexpected output data=%h hi=%b lo=%b", out_data, out_sat_hi, out_sat_lo);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.data || out_sat_hi !== e.hi || out_sat_lo !== e.lo) begin
                        bad++;
                        $display("FAIL out_beat got data=%h hi=%b lo=%b want data=%h hi=%b lo=%b",
                                 out_data, out_sat_hi, out_sat_lo, e.data, e.hi, e.lo);
                    end
                    if (e.lat) begin
                        total++;
                        if (cyc - e.acc != 2) begin
                            bad++;
                            $display("FAIL latency got=%0d want=2", cyc - e.acc);
                        end
                    end
                end
            end
            if (clr_count) cnt_m = 0;
            else if (out_valid && out_ready && ((|out_sat_hi) || (|out_sat_lo)) && cnt_m < (2 ** CNT_W) - 1)
                cnt_m++;
        end
    end

    // in_ready must drop only when two beats are in flight and out_ready is low
    always @(posedge CLK) begin : p_ready_chk
        logic exp_ir;
        #3;
        exp_ir = !RST && !(sb.size() == 2 && !out_ready);
        total++;
        if (in_ready !== exp_ir) begin
            bad++;
            $display("FAIL in_ready got=%b want=%b (in flight %0d, out_ready %b)", in_ready, exp_ir, sb.size(), out_ready);
        end
    end

    // Downstream back-pressure generator
    initial begin : p_bp
        forever begin
            @(posedge CLK);
            #1;
            if (bp_mode == 0)      out_ready = 1'b1;
            else if (bp_mode == 1) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic set_bp(input int mode, input logic rdy);
        @(posedge CLK);
        #1;
        bp_mode   = mode;
        out_ready = rdy;
    endtask

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input bit rnd, input bit off);
        bit ok;
        @(posedge CLK);
        #1;
        in_valid    = 1'b1;
        in_data     = {b, a};
        mode_round  = rnd;
        mode_offset = off;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout beat %h not accepted within 200 cycles", {b, a});
        end
    endtask

    task automatic idle();
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout got=%0d beats outstanding want=0", sb.size());
        end
        repeat (2) @(negedge CLK);
    endtask

    initial begin : p_main
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_flags", 32'({out_sat_hi, out_sat_lo}), 32'd0);
        check("reset_count", 32'(sat_count), 32'd0);

        // 0.5 in both formats
        send(16'h0200, 16'h0200, 1'b0, 1'b0);
        send(16'h0200, 16'hFE00, 1'b0, 1'b1);
        // +1.0, -1.0, -2.0 boundaries
        send(16'h0400, 16'hFC00, 1'b0, 1'b0);
        send(16'h0400, 16'hFC00, 1'b0, 1'b1);
        send(16'hF800, 16'h0000, 1'b0, 1'b0);
        send(16'hF800, 16'h0000, 1'b0, 1'b1);
        // Rounding cases, including rounding into saturation
        send(16'h0004, 16'hFFFC, 1'b0, 1'b0);
        send(16'h0004, 16'hFFFC, 1'b1, 1'b0);
        send(16'h03FC, 16'h03FC, 1'b0, 1'b0);
        send(16'h03FC, 16'hFC04, 1'b1, 1'b0);
        idle();
        drain();

        // Random data under random back-pressure
        set_bp(1, 1'b1);
        for (int i = 0; i < 20; i++)
            send(rand_x(), rand_x(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        idle();
        drain();
        set_bp(0, 1'b1);

        // Counter: clear, five flagged transfers
        @(posedge CLK);
        #1;
        clr_count = 1'b1;
        @(posedge CLK);
        #1;
        clr_count = 1'b0;
        for (int i = 0; i < 5; i++) send(16'h0400, 16'h0000, 1'b0, 1'b0);
        idle();
        drain();
        check("count_five", 32'(sat_count), 32'd5);

        // Stalled saturated beat, then clear in the same cycle it transfers
        set_bp(2, 1'b0);
        send(16'h0400, 16'hF800, 1'b0, 1'b0);
        idle();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("stall_hold_valid", 32'(out_valid), 32'd1);
        check("stall_hold_data", 32'(out_data), 32'h807F);
        @(posedge CLK);
        #1;
        out_ready = 1'b1;
        clr_count = 1'b1;
        @(posedge CLK);
        #1;
        clr_count = 1'b0;
        @(negedge CLK);
        check("count_clear_wins", 32'(sat_count), 32'd0);
        set_bp(0, 1'b1);

        // Reset with both stages occupied
        send(16'hF800, 16'h0000, 1'b0, 1'b0);
        idle();
        drain();
        set_bp(2, 1'b0);
        send(16'h0200, 16'h0200, 1'b0, 1'b0);
        send(16'h0400, 16'h0400, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        RST      = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        @(posedge CLK);
        #1;
        RST       = 1'b0;
        bp_mode   = 0;
        out_ready = 1'b1;
        @(negedge CLK);
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_out_data", 32'(out_data), 32'd0);
        check("rst_mid_flags", 32'({out_sat_hi, out_sat_lo}), 32'd0);
        check("rst_mid_count", 32'(sat_count), 32'd0);
        send(16'h0200, 16'hFE00, 1'b0, 1'b0);
        idle();
        drain();

        // Counter ceiling on a 3-bit counter instance
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            small_valid = 1'b1;
            in_data     = {16'hF800, 16'h0400};
            mode_round  = 1'b0;
            mode_offset = 1'b0;
        end
        @(posedge CLK);
        #1;
        small_valid = 1'b0;
        repeat (4) @(negedge CLK);
        check("small_count_three", 32'(small_count), 32'd3);
        for (int i = 0; i < 7; i++) begin
            @(posedge CLK);
            #1;
            small_valid = 1'b1;
        end
        @(posedge CLK);
        #1;
        small_valid = 1'b0;
        repeat (4) @(negedge CLK);
        check("small_count_sticks", 32'(small_count), 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
